// File: rtl/status_7seg_pkg.sv
// Shared constants and the segment pattern table for the status 7-segment driver.
// Segment order is {g,f,e,d,c,b,a}; all patterns are active low.
package status_7seg_pkg;

    localparam logic [5:0]  CH_BLANK = 6'h10;
    localparam logic [5:0]  CH_DASH  = 6'h1D;
    localparam int unsigned DP_BIT   = 5;
    localparam logic [6:0]  SEG_OFF  = 7'h7F;

    typedef struct packed {
        logic       dp;
        logic [6:0] seg;
    } seg_pattern_t;

    // Index is code[4:0]: hex digits, blank, then the letter/symbol set.
    localparam logic [6:0] SEG_TABLE [32] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,  // 0-7
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,  // 8-F
        7'h7F, 7'h42, 7'h09, 7'h4F, 7'h61, 7'h47, 7'h2B, 7'h23,  // blank G H I J L n o
        7'h0C, 7'h2F, 7'h12, 7'h07, 7'h41, 7'h3F, 7'h77, 7'h11   // P r S t U - _ y
    };

endpackage

// File: rtl/status_7seg_decode.sv
// Combinational character-code to {dp, seg} lookup; outputs are active low.
module status_7seg_decode
    import status_7seg_pkg::*;
(
    input  logic [5:0]   code,
    output seg_pattern_t pattern
);

    // Table lookup on the low five bits; bit 5 lights the decimal point.
    always_comb begin
        pattern.seg = SEG_TABLE[code[4:0]];
        pattern.dp  = ~code[DP_BIT];
    end

endmodule

// File: rtl/status_7seg_driver.sv
// Time-multiplexes eight character codes onto an 8-digit common-anode display.
// Each digit slot starts with all anodes off so the segments can switch
// without ghosting; the eight codes are captured together once per frame.
// Optional macro STATUS_7SEG_DIM_EN adds a 4-bit PWM brightness input.
module status_7seg_driver
    import status_7seg_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 12500,
    parameter int unsigned BLANK_CYCLES = 100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] display0,
    input  logic [5:0] display1,
    input  logic [5:0] display2,
    input  logic [5:0] display3,
    input  logic [5:0] display4,
    input  logic [5:0] display5,
    input  logic [5:0] display6,
    input  logic [5:0] display7,
`ifdef STATUS_7SEG_DIM_EN
    input  logic [3:0] brightness,
`endif
    output logic [6:0] seg,
    output logic       dp,
    output logic [7:0] an
);

    localparam int unsigned    CW       = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0]  SLOT_END = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0]  BLANK_AT = CW'(BLANK_CYCLES);

    logic [CW-1:0] slot_cnt;
    logic [CW-1:0] slot_next;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic [5:0]    shadow [8];
    logic [5:0]    live   [8];
    logic          slot_wrap;
    logic          frame_wrap;
    logic          anode_on;
    logic [5:0]    code_next;
    logic [7:0]    an_next;
    seg_pattern_t  pat_next;

`ifdef STATUS_7SEG_DIM_EN
    logic [3:0]    pwm;
    logic [3:0]    pwm_next;
    logic [3:0]    bright_q;
    logic [3:0]    bright_next;
`endif

    // Next slot/index state and the code for the slot being entered.
    // Outputs are computed from the post-edge state so that the registered
    // seg/an line up with the slot counter; at a frame wrap the fresh input
    // bypasses the shadow bank because both load on the same edge.
    always_comb begin
        live       = '{display0, display1, display2, display3,
                       display4, display5, display6, display7};
        slot_wrap  = (slot_cnt == SLOT_END);
        slot_next  = slot_wrap ? '0 : slot_cnt + 1'b1;
        idx_next   = slot_wrap ? idx + 3'd1 : idx;
        frame_wrap = slot_wrap && (idx == 3'd7);
        code_next  = frame_wrap ? live[idx_next] : shadow[idx_next];
        anode_on   = (slot_next >= BLANK_AT);
`ifdef STATUS_7SEG_DIM_EN
        pwm_next    = pwm + 4'd1;
        bright_next = frame_wrap ? brightness : bright_q;
        anode_on    = anode_on && (pwm_next < bright_next);
`endif
        an_next = anode_on ? ~(8'h80 >> idx_next) : 8'hFF;
    end

    status_7seg_decode u_decode (
        .code    (code_next),
        .pattern (pat_next)
    );

    // Slot/index counters, frame capture and registered display outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_cnt <= '0;
            idx      <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                shadow[i] <= CH_BLANK;
            end
            an  <= 8'hFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
`ifdef STATUS_7SEG_DIM_EN
            pwm      <= '0;
            bright_q <= '0;
`endif
        end else begin
            slot_cnt <= slot_next;
            idx      <= idx_next;
            an       <= an_next;
            if (frame_wrap) begin
                for (int unsigned i = 0; i < 8; i++) begin
                    shadow[i] <= live[i];
                end
            end
            if (slot_wrap) begin
                seg <= pat_next.seg;
                dp  <= pat_next.dp;
            end
`ifdef STATUS_7SEG_DIM_EN
            pwm <= pwm_next;
            if (frame_wrap) begin
                bright_q <= brightness;
            end
`endif
        end
    end

endmodule

// File: tb/tb_status_7seg_driver.sv
// Self-checking bench for status_7seg_driver with short slots.
// The reference model derives slot, digit and frame from the number of clock
// edges since reset and decodes codes from segment-letter strings.
module tb_status_7seg_driver;

    localparam int unsigned D = 8;
    localparam int unsigned B = 2;
    localparam int unsigned F = 8 * D;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [5:0] disp [8];
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
`ifdef STATUS_7SEG_DIM_EN
    logic [3:0] brightness = 4'd15;
    logic [3:0] cap_bright;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    status_7seg_driver #(
        .DIGIT_CYCLES (D),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .display0   (disp[0]),
        .display1   (disp[1]),
        .display2   (disp[2]),
        .display3   (disp[3]),
        .display4   (disp[4]),
        .display5   (disp[5]),
        .display6   (disp[6]),
        .display7   (disp[7]),
`ifdef STATUS_7SEG_DIM_EN
        .brightness (brightness),
`endif
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    // Lit segments per code[4:0], written as segment letters.
    string lit [32] = '{
        "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg",
        "", "acdef", "bcefg", "ef", "bcde", "def", "ceg", "cdeg",
        "abefg", "eg", "acdfg", "defg", "bcdef", "g", "d", "bcdfg"
    };

    // Model state: edges since reset release and the codes captured per frame.
    int unsigned t;
    logic [5:0]  cap [8];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            t = 0;
            for (int i = 0; i < 8; i++) cap[i] = 6'h10;
`ifdef STATUS_7SEG_DIM_EN
            cap_bright = 4'd0;
`endif
        end else begin
            t = t + 1;
            if (t % F == 0) begin
                for (int i = 0; i < 8; i++) cap[i] = disp[i];
`ifdef STATUS_7SEG_DIM_EN
                cap_bright = brightness;
`endif
            end
        end
    end

    function automatic logic [6:0] seg_of(input logic [5:0] code);
        logic [6:0] on;
        string      s;
        on = 7'd0;
        s  = lit[code[4:0]];
        for (int i = 0; i < s.len(); i++) on[int'(s[i]) - 97] = 1'b1;
        return ~on;
    endfunction

    function automatic logic [7:0] exp_an();
        int unsigned slot = t % D;
        int unsigned idx  = (t / D) % 8;
        if (slot < B) return 8'hFF;
`ifdef STATUS_7SEG_DIM_EN
        if ((t % 16) >= cap_bright) return 8'hFF;
`endif
        return ~(8'h80 >> idx);
    endfunction

    function automatic logic [6:0] exp_seg();
        if (t < F) return 7'h7F;
        return seg_of(cap[(t / D) % 8]);
    endfunction

    function automatic logic exp_dp();
        if (t < F) return 1'b1;
        return ~cap[(t / D) % 8][5];
    endfunction

    // Anti-ghosting: a segment change is only allowed with every anode off.
    logic [6:0] prev_seg;
    always @(negedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_seg = 7'h7F;
        end else begin
            vectors++;
            if (seg !== prev_seg && an !== 8'hFF) begin
                miscompares++;
                $display("FAIL ghost t=%0d seg %h->%h while an=%h (required an=ff)", t, prev_seg, seg, an);
            end
            prev_seg = seg;
        end
    end

    task automatic wait_phase(input int unsigned ph);
        int n = 0;
        while ((t % F) != ph && n <= int'(F)) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if ((t % F) != ph) begin
            miscompares++;
            $display("FAIL align got phase %0d required %0d", t % F, ph);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 8; i++) disp[i] = 6'h00;
        repeat (3) @(negedge clk);
        vectors++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
            miscompares++;
            $display("FAIL reset got an=%h seg=%h dp=%b required an=ff seg=7f dp=1", an, seg, dp);
        end
        resetn = 1'b1;
    endtask

    task automatic test_all_zero();
        for (int n = 0; n < int'(3 * F); n++) begin
            @(negedge clk);
            vectors++;
            if (an !== exp_an() || seg !== exp_seg() || dp !== exp_dp()) begin
                miscompares++;
                $display("FAIL all_zero t=%0d got an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                         t, an, seg, dp, exp_an(), exp_seg(), exp_dp());
            end
        end
    endtask

    task automatic test_single_digit();
        for (int i = 0; i < 8; i++) disp[i] = 6'h10;
        disp[3] = 6'h25;
        for (int n = 0; n < int'(2 * F); n++) begin
            @(negedge clk);
            vectors++;
            if (an !== exp_an() || seg !== exp_seg() || dp !== exp_dp()) begin
                miscompares++;
                $display("FAIL single_digit t=%0d got an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                         t, an, seg, dp, exp_an(), exp_seg(), exp_dp());
            end
        end
        wait_phase(3 * D + B);
        vectors++;
`ifdef STATUS_7SEG_DIM_EN
        if (seg !== 7'h12 || dp !== 1'b0) begin
`else
        if (an !== 8'hEF || seg !== 7'h12 || dp !== 1'b0) begin
`endif
            miscompares++;
            $display("FAIL digit3 got an=%h seg=%h dp=%b required an=ef seg=12 dp=0", an, seg, dp);
        end
    endtask

    task automatic test_mid_frame_change();
        disp[0] = 6'h01;
        disp[3] = 6'h10;
        wait_phase(1);
        wait_phase(B);
        vectors++;
        if (seg !== 7'h79) begin
            miscompares++;
            $display("FAIL old_code got seg=%h required seg=79", seg);
        end
        wait_phase(4 * D);
        disp[0] = 6'h1D;
        for (int n = 0; n < int'(F); n++) begin
            @(negedge clk);
            vectors++;
            if (an !== exp_an() || seg !== exp_seg() || dp !== exp_dp()) begin
                miscompares++;
                $display("FAIL mid_change t=%0d got an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                         t, an, seg, dp, exp_an(), exp_seg(), exp_dp());
            end
        end
        wait_phase(B);
        vectors++;
        if (seg !== 7'h3F) begin
            miscompares++;
            $display("FAIL new_code got seg=%h required seg=3f", seg);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < int'(6 * F); n++) begin
            @(negedge clk);
            vectors++;
            if (an !== exp_an() || seg !== exp_seg() || dp !== exp_dp()) begin
                miscompares++;
                $display("FAIL random t=%0d got an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                         t, an, seg, dp, exp_an(), exp_seg(), exp_dp());
            end
            if ($urandom_range(0, 9) == 0) disp[$urandom_range(0, 7)] = 6'($urandom);
        end
    endtask

    task automatic test_decode_all();
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 8; k++) disp[k] = 6'(b * 8 + k);
            wait_phase(1);
            for (int n = 0; n < int'(F); n++) begin
                @(negedge clk);
                vectors++;
                if (an !== exp_an() || seg !== exp_seg() || dp !== exp_dp()) begin
                    miscompares++;
                    $display("FAIL decode code=%h t=%0d got an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                             cap[(t / D) % 8], t, an, seg, dp, exp_an(), exp_seg(), exp_dp());
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 8; k++) disp[k] = 6'h08;
        wait_phase(1);
        wait_phase(6 * D + 5);
        #2 resetn = 1'b0;
        #1;
        vectors++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset got an=%h seg=%h dp=%b required an=ff seg=7f dp=1", an, seg, dp);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int n = 0; n < int'(2 * F); n++) begin
            @(negedge clk);
            vectors++;
            if (an !== exp_an() || seg !== exp_seg() || dp !== exp_dp()) begin
                miscompares++;
                $display("FAIL after_reset t=%0d got an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                         t, an, seg, dp, exp_an(), exp_seg(), exp_dp());
            end
        end
    endtask

`ifdef STATUS_7SEG_DIM_EN
    task automatic test_dim();
        int lows;
        for (int pass = 0; pass < 2; pass++) begin
            brightness = (pass == 0) ? 4'd4 : 4'd0;
            wait_phase(1);
            lows = 0;
            for (int n = 0; n < int'(2 * F); n++) begin
                @(negedge clk);
                if (an !== 8'hFF) lows++;
                vectors++;
                if (an !== exp_an() || seg !== exp_seg() || dp !== exp_dp()) begin
                    miscompares++;
                    $display("FAIL dim b=%0d t=%0d got an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                             brightness, t, an, seg, dp, exp_an(), exp_seg(), exp_dp());
                end
            end
            if (pass == 1) begin
                vectors++;
                if (lows != 0) begin
                    miscompares++;
                    $display("FAIL dim_off got %0d anode-low cycles required 0", lows);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_all_zero();
        test_single_digit();
        test_mid_frame_change();
        test_random();
        test_decode_all();
        test_mid_reset();
`ifdef STATUS_7SEG_DIM_EN
        test_dim();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
